// File: rtl/hilo_muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_ctrl
//   Multi-cycle multiply/divide unit with the HI/LO register pair for a
//   MIPS-style EX stage. A multiply takes one extra cycle. A divide runs a
//   32-step restoring division. Either one finishes with a DONE cycle that
//   writes HI/LO. MTHI/MTLO write HI/LO directly from IDLE without stalling.
//
// Ports
//   clk          : sole clock, rising edge
//   rst          : synchronous active-high reset
//   alu_control  : EX-stage operation code (mult/div/mthi/mtlo; others ignored)
//   valid        : EX instruction is live (held with stable operands while stalled)
//   flush        : EX is annulled; abandons any operation in flight
//   src_a, src_b : rs / rt operands
//   stall_req    : hold IF..EX this cycle (combinational)
//   hi_out       : HI register contents
//   lo_out       : LO register contents
//   busy         : unit is in a state other than IDLE
// ---------------------------------------------------------------------------
module hilo_muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  alu_control,
  input  logic        valid,
  input  logic        flush,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stall_req,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy
);

  // Operation codes shared with the ALU decoder.
  localparam logic [4:0] ALU_SIGNED_MULT   = 5'h0C;
  localparam logic [4:0] ALU_UNSIGNED_MULT = 5'h0D;
  localparam logic [4:0] ALU_SIGNED_DIV    = 5'h0E;
  localparam logic [4:0] ALU_UNSIGNED_DIV  = 5'h0F;
  localparam logic [4:0] ALU_MTHI          = 5'h10;
  localparam logic [4:0] ALU_MTLO          = 5'h11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state;
  // acc holds the 64-bit product for a multiply. For a divide it is the
  // {partial remainder, dividend/quotient} shift register.
  logic [63:0] acc;
  logic [31:0] divisor;
  logic [5:0]  count;
  logic        op_div;
  logic        neg_q;
  logic        neg_r;

  logic        is_mult;
  logic        is_div;
  logic        op_signed;
  logic        accept;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] product;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [63:0] shifted;
  logic [32:0] trial;
  logic [63:0] div_next;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    is_mult   = (alu_control == ALU_SIGNED_MULT) || (alu_control == ALU_UNSIGNED_MULT);
    is_div    = (alu_control == ALU_SIGNED_DIV)  || (alu_control == ALU_UNSIGNED_DIV);
    op_signed = (alu_control == ALU_SIGNED_MULT) || (alu_control == ALU_SIGNED_DIV);
    accept    = (state == S_IDLE) && valid && !flush && (is_mult || is_div);

    // Signed mult sign-extends both operands. Unsigned mult zero-extends them.
    // The low 64 bits of the 64x64 product are then correct in both cases.
    ext_a   = op_signed ? {{32{src_a[31]}}, src_a} : {32'b0, src_a};
    ext_b   = op_signed ? {{32{src_b[31]}}, src_b} : {32'b0, src_b};
    product = ext_a * ext_b;

    abs_a = (op_signed && src_a[31]) ? -src_a : src_a;
    abs_b = (op_signed && src_b[31]) ? -src_b : src_b;

    // One restoring step: shift left, then try to subtract the divisor from
    // the upper 33 bits. Bit 32 of the trial difference set means a borrow,
    // so the shifted value is kept unchanged.
    shifted  = {acc[62:0], 1'b0};
    trial    = acc[63:31] - {1'b0, divisor};
    div_next = trial[32] ? shifted : {trial[31:0], acc[30:0], 1'b1};

    // Division by zero naturally yields quotient all-ones and remainder |a|.
    // neg_q is kept clear in that case, so LO stays all-ones. The remainder
    // sign fix-up turns |a| back into the original a.
    quot_fix = neg_q ? -acc[31:0]  : acc[31:0];
    rem_fix  = neg_r ? -acc[63:32] : acc[63:32];

    // Reset and flush both force the stall low in the same cycle.
    stall_req = !rst && !flush && (accept || (state == S_MUL) || (state == S_DIV));
    busy      = !rst && (state != S_IDLE);
  end

  // NOTE: state is updated with non-blocking assignments only. All registers
  // read this edge's old values, whatever order the statements are in.
  always_ff @(posedge clk) begin
    // NOTE: every register here is a flop, not a memory array, so each one
    // goes through reset and the unit comes up in a fully known state.
    if (rst) begin
      state   <= S_IDLE;
      acc     <= '0;
      divisor <= '0;
      count   <= '0;
      op_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      hi_out  <= '0;
      lo_out  <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && is_mult) begin
            acc    <= product;
            op_div <= 1'b0;
            state  <= S_MUL;
          end else if (accept) begin
            acc     <= {32'b0, abs_a};
            divisor <= abs_b;
            count   <= 6'd32;
            op_div  <= 1'b1;
            neg_q   <= op_signed && (src_a[31] ^ src_b[31]) && (src_b != 32'b0);
            neg_r   <= op_signed && src_a[31];
            state   <= S_DIV;
          end else if (valid && (alu_control == ALU_MTHI)) begin
            hi_out <= src_a;
          end else if (valid && (alu_control == ALU_MTLO)) begin
            lo_out <= src_a;
          end
        end
        S_MUL: state <= S_DONE;
        S_DIV: begin
          acc   <= div_next;
          count <= count - 6'd1;
          if (count == 6'd1) state <= S_DONE;
        end
        default: begin  // S_DONE
          if (op_div) begin
            hi_out <= rem_fix;
            lo_out <= quot_fix;
          end else begin
            hi_out <= acc[63:32];
            lo_out <= acc[31:0];
          end
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/hilo_muldiv_ctrl.md
HILO_MULDIV_CTRL -- requirements
Module: hilo_muldiv_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port alu_control, input, 5: EX-stage op, encoded per aludefines.vh (ALU_SIGNED_MULT, ALU_UNSIGNED_MULT, ALU_SIGNED_DIV, ALU_UNSIGNED_DIV, ALU_MTHI, ALU_MTLO); other codes are ignored.
REQ-004 SHALL have port valid, input, 1: EX instruction is live; held high with unchanged operands while stall_req=1.
REQ-005 SHALL have port flush, input, 1: EX is being annulled (exception/eret).
REQ-006 SHALL have ports src_a and src_b, input, 32: rs and rt operands.
REQ-007 SHALL have port stall_req, output, 1: pipeline must hold IF..EX this cycle.
REQ-008 SHALL have ports hi_out and lo_out, output, 32: current HI/LO register contents, for MFHI/MFLO.
REQ-009 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-010 SHALL implement states IDLE, MUL, DIV, DONE; exactly one state per cycle.
REQ-011 Accept condition: state IDLE, valid=1, flush=0, alu_control a mult/div code.
REQ-012 On accept of mult, SHALL latch 64-bit product (signed: both operands two's complement; unsigned: zero-extended) and go to MUL; stall_req=1 in accept cycle.
REQ-013 MUL SHALL go to DONE next cycle; stall_req=1 in MUL.
REQ-014 On accept of div, SHALL latch |src_a|, |src_b| (signed) or raw (unsigned), sign flags, load 6-bit counter with 32, go to DIV; stall_req=1 in accept cycle.
REQ-015 DIV SHALL perform one restoring-division iteration per cycle (shift 64-bit partial remainder left, trial-subtract divisor, set quotient bit), decrement counter, and go to DONE when counter reaches 0 after the 32nd iteration; stall_req=1 throughout DIV.
REQ-016 Signed results SHALL be fixed up in DONE: quotient negated if sign(a)^sign(b), remainder takes sign of a.
REQ-017 src_b=0 SHALL complete with normal latency and write LO=32'hFFFF_FFFF, HI=src_a (signed and unsigned).
REQ-018 Signed 32'h8000_0000 / 32'hFFFF_FFFF SHALL write LO=32'h8000_0000, HI=0.
REQ-019 In DONE, stall_req=0, HI<=upper/remainder, LO<=lower/quotient on the edge ending DONE, next state IDLE; the still-high valid of the same instruction in DONE SHALL NOT cause a re-accept.
REQ-020 Latency: mult accept at cycle T -> stall_req high T..T+1, HI/LO updated edge ending T+2; div accept at T -> stall_req high T..T+32, HI/LO updated edge ending T+33.
REQ-021 In IDLE with valid=1, flush=0: ALU_MTHI SHALL write HI<=src_a, ALU_MTLO SHALL write LO<=src_a at that edge, no stall, no state change.
REQ-022 flush=1 in any state SHALL return to IDLE next cycle with no HI/LO write, and SHALL force stall_req=0 that cycle; flush has priority over accept, MTHI/MTLO and DONE writeback.
REQ-023 hi_out/lo_out SHALL be direct register outputs (updated value visible the cycle after the write edge).
REQ-024 stall_req SHALL be combinational from state, valid, flush and alu_control only.

Reset
REQ-025 rst=1 SHALL force state IDLE, HI=0, LO=0, counter=0, all operand/partial registers=0, on the next edge regardless of state, including mid-division.
REQ-026 While rst=1, stall_req=0, busy=0; no accept occurs in a reset cycle.

Verification
REQ-027 Unsigned div 100/7 -> stall_req high 33 cycles, then LO=14, HI=2.
REQ-028 Signed div -7/2 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF; signed 0x80000000/-1 -> LO=0x80000000, HI=0; div by 0 with src_a=5 -> LO=0xFFFFFFFF, HI=5.
REQ-029 Signed mult 0xFFFFFFFF*2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE; unsigned same operands -> HI=1, LO=0xFFFFFFFE; stall_req high exactly 2 cycles.
REQ-030 MTHI src_a=0x12345678 in IDLE -> hi_out=0x12345678 next cycle, stall_req never high.
REQ-031 flush at iteration 10 of a div -> IDLE next cycle, HI/LO unchanged, stall_req=0; rst at iteration 20 -> HI=LO=0, busy=0.
REQ-032 Back-to-back div then mult with valid held -> second op accepted only in cycle after DONE, each result written exactly once.
